// File: rtl/fir_sample_feeder.sv
// Buffered sample source for fir_filter: FIFO-backed, rate-divided strobes, zero flush on stop.
// Build option FEEDER_LOOP_EN: popped samples are rewritten at the tail for circular playback.
module fir_sample_feeder #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int FLUSH_LEN = 4,
  parameter int DIV_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic [ADDR_W:0]   level,
  input  logic              start,
  input  logic              stop,
  input  logic [DIV_W-1:0]  rate_div,
  output logic [DATA_W-1:0] x_out,
  output logic              x_valid,
  output logic              busy,
  output logic              underrun,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam int              FC_W       = $clog2(FLUSH_LEN) + 1;
  localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(FLUSH_LEN - 1);
  localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W + 1)'(DEPTH);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [ADDR_W:0]     r_level;
  logic [DIV_W-1:0]    r_div_cnt;
  logic [FC_W-1:0]     r_flush_cnt;
  logic [DATA_W-1:0]   r_x_out;
  logic                r_x_valid;
  logic                r_busy;
  logic                r_underrun;

  logic                w_tick;
  logic                w_run_strobe;
  logic                w_flush_strobe;
  logic                w_empty;
  logic                w_pop;
  logic                w_push;
  logic [DATA_W-1:0]   w_push_data;
  logic [DATA_W-1:0]   w_head;
  logic                w_entry;

  assign w_empty = (r_level == '0);
  assign w_head  = r_mem[r_rd_ptr];
  // >= rather than == so a live shrink of rate_div below the count still ticks at once.
  assign w_tick  = (r_state != S_IDLE) && (r_div_cnt >= rate_div);

  always_comb begin
    w_state_nxt    = r_state;
    w_run_strobe   = 1'b0;
    w_flush_strobe = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (stop)        w_state_nxt  = S_FLUSH;
        else if (w_tick) w_run_strobe = 1'b1;
      end
      S_FLUSH: begin
        if (w_tick) begin
          w_flush_strobe = 1'b1;
          if (r_flush_cnt == FLUSH_LAST) w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_pop   = w_run_strobe && !w_empty;
  assign w_entry = (w_state_nxt != r_state) && (w_state_nxt != S_IDLE);

`ifdef FEEDER_LOOP_EN
  // The popped head goes back in at the tail; host writes are locked out while streaming.
  assign w_push      = w_pop || (wr_en && !full && !r_busy);
  assign w_push_data = w_pop ? w_head : wr_data;
`else
  assign w_push      = wr_en && !full;
  assign w_push_data = wr_data;
`endif

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_div_cnt   <= '0;
      r_flush_cnt <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      if (w_entry || (r_state == S_IDLE) || w_tick) r_div_cnt <= '0;
      else                                          r_div_cnt <= r_div_cnt + 1'b1;
      if (w_entry)             r_flush_cnt <= '0;
      else if (w_flush_strobe) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x_out    <= '0;
      r_x_valid  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_x_valid <= w_run_strobe || w_flush_strobe;
      if (w_pop)                                r_x_out <= w_head;
      else if (w_run_strobe || w_flush_strobe)  r_x_out <= '0;
      if ((r_state == S_IDLE) && start && !stop) r_underrun <= 1'b0;
      else if (w_run_strobe && w_empty)          r_underrun <= 1'b1;
    end
  end

  assign full      = (r_level == LEVEL_FULL);
  assign level     = r_level;
  assign x_out     = r_x_out;
  assign x_valid   = r_x_valid;
  assign busy      = r_busy;
  assign underrun  = r_underrun;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Bench for fir_sample_feeder: queue-based sample model, expected strobes checked by a negedge monitor.
module tb_fir_sample_feeder;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int FL    = 4;
  localparam int DIVW  = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            wr_en = 1'b0;
  logic [DW-1:0]   wr_data = '0;
  logic            start = 1'b0;
  logic            stop = 1'b0;
  logic [DIVW-1:0] rate_div = '0;
  logic            full;
  logic [AW:0]     level;
  logic [DW-1:0]   x_out;
  logic            x_valid;
  logic            busy;
  logic            underrun;
  logic [1:0]      dbg_state;

  fir_sample_feeder #(
    .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .FLUSH_LEN(FL), .DIV_W(DIVW)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full), .level(level),
    .start(start), .stop(stop), .rate_div(rate_div), .x_out(x_out), .x_valid(x_valid),
    .busy(busy), .underrun(underrun), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc = 0;
  logic [DW-1:0] exp_q[$];
  int            gap_q[$];
  logic [DW-1:0] fifo_m[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the head of the expected queue, including its spacing.
  always @(negedge clk) begin
    if (rst && x_valid) begin
      if (exp_q.size() == 0) begin
        chk("strobe_expected", exp_q.size(), 1);
      end else begin
        logic [DW-1:0] v;
        int g;
        v = exp_q.pop_front();
        g = gap_q.pop_front();
        chk("x_out", x_out, v);
        if (g != 0) chk("strobe_gap", cyc - last_cyc, g);
      end
      last_cyc = cyc;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    fifo_m.delete();
    exp_q.delete();
    gap_q.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic write_seq(input int n, input bit rnd, input int base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = rnd ? DW'($urandom_range(0, 255)) : DW'(base + i);
      if (fifo_m.size() < DEPTH) fifo_m.push_back(wr_data);
    end
    @(negedge clk);
    wr_en = 1'b0;
    chk("level_after_write", level, fifo_m.size());
    chk("full_after_write", full, (fifo_m.size() == DEPTH) ? 1 : 0);
  endtask

  // Predict the sample each RUN strobe carries from the FIFO model, then FL flush zeros.
  task automatic expect_run(input int rd, input int k, output bit und);
    logic [DW-1:0] v;
    und = 1'b0;
    for (int i = 0; i < k; i++) begin
      if (fifo_m.size() > 0) begin
        v = fifo_m.pop_front();
`ifdef FEEDER_LOOP_EN
        fifo_m.push_back(v);
`endif
      end else begin
        v = '0;
        und = 1'b1;
      end
      exp_q.push_back(v);
      gap_q.push_back((i == 0) ? 0 : rd + 1);
    end
  endtask

  task automatic run_stream(input int rd, input int k);
    bit und;
    int got = 0;
    rate_div = DIVW'(rd);
    expect_run(rd, k, und);
    for (int j = 0; j < FL; j++) begin
      exp_q.push_back('0);
      gap_q.push_back((j == 0) ? rd + 2 : rd + 1);
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_run", busy, 1);
    for (int c = 0; c < 500 && got < k; c++) begin
      @(negedge clk);
      if (x_valid) got++;
    end
    chk("run_strobes", got, k);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    for (int c = 0; c < 500 && busy; c++) @(negedge clk);
    chk("busy_idle", busy, 0);
    chk("underrun", underrun, und ? 1 : 0);
    chk("level_after_stream", level, fifo_m.size());
    chk("full_after_stream", full, (fifo_m.size() == DEPTH) ? 1 : 0);
    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    bit und;
    int got;

    // Reset with a sample already written.
    repeat (2) @(negedge clk);
    rst = 1'b1;
    write_seq(1, 1'b0, 42);
    #2 rst = 1'b0;
    #1;
    chk("rst_x_out", x_out, 0);
    chk("rst_x_valid", x_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_full", full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_underrun", underrun, 0);
    fifo_m.delete();
    @(negedge clk);
    rst = 1'b1;

    // Back-to-back samples then an underrun zero.
    do_reset();
    write_seq(4, 1'b0, 1);
    run_stream(0, 5);

    // Divided rate.
    do_reset();
    write_seq(2, 1'b0, 5);
    run_stream(2, 2);

    // Stop after two strobes leaves four samples behind.
    do_reset();
    write_seq(6, 1'b0, 1);
    run_stream(0, 2);

    // Overfill: the 17th write is dropped.
    do_reset();
    write_seq(17, 1'b0, 100);
    run_stream(0, 16);

    // Asynchronous reset in the middle of RUN.
    do_reset();
    write_seq(5, 1'b0, 9);
    rate_div = DIVW'(4);
    expect_run(4, 2, und);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 0;
    for (int c = 0; c < 200 && got < 2; c++) begin
      @(negedge clk);
      if (x_valid) got++;
    end
    chk("mid_run_strobes", got, 2);
    chk("mid_run_level", level, fifo_m.size());
    #2 rst = 1'b0;
    #1;
    chk("async_x_out", x_out, 0);
    chk("async_x_valid", x_valid, 0);
    chk("async_level", level, 0);
    chk("async_busy", busy, 0);
    chk("async_full", full, 0);
    chk("async_underrun", underrun, 0);
    fifo_m.delete();
    exp_q.delete();
    gap_q.delete();
    @(negedge clk);
    rst = 1'b1;
    run_stream(1, 2);

    // start and stop together keep the feeder idle.
    @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    @(negedge clk);
    chk("start_stop_idle", busy, 0);

    // Two samples streamed long enough to show playback (or the drain in the default build).
    do_reset();
    write_seq(2, 1'b0, 7);
    run_stream(0, 6);

    // Randomized streams; FIFO contents carry over between them.
    for (int t = 0; t < 8; t++) begin
      write_seq($urandom_range(0, 18), 1'b1, 0);
      run_stream($urandom_range(0, 3), $urandom_range(1, fifo_m.size() + 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fir_sample_feeder.md
Name: fir_sample_feeder

Overview:
- Streaming sample source that drives the 8-bit input of `fir_filter` from a buffered sample store.
- Host/testbench logic writes samples into an internal FIFO; the feeder issues them to the filter at a programmable rate.
- On stop, it pushes zero samples to flush the filter's delay line.
- Sits directly upstream of `fir_filter`, opposite end of its `x_in` interface.

Parameters:
- DATA_W, 8, sample width; matches filter input width.
- DEPTH, 16, FIFO entries; must be a power of 2.
- ADDR_W, 4, log2(DEPTH).
- FLUSH_LEN, 4, zero samples emitted in FLUSH; equals the filter tap count.
- DIV_W, 8, width of the rate divider.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe into FIFO.
- wr_data  in  DATA_W  sample to write.
- full  out  1  FIFO holds DEPTH entries.
- level  out  ADDR_W+1  current FIFO occupancy, 0..DEPTH.
- start  in  1  single-cycle pulse: begin streaming.
- stop  in  1  single-cycle pulse: end streaming and flush.
- rate_div  in  DIV_W  sample period minus 1, in clk cycles.
- x_out  out  DATA_W  sample to filter `x_in`.
- x_valid  out  1  one-cycle strobe, x_out updated.
- busy  out  1  state != IDLE.
- underrun  out  1  sticky: a sample was due while the FIFO was empty.

Behaviour:
- Reset (rst=0, asynchronous assert, synchronous release):
  - state=IDLE; FIFO pointers and level=0; divider=0.
  - x_out=0, x_valid=0, underrun=0, full=0, busy=0.
- FIFO:
  - Write accepted when wr_en && !full, in any state.
  - Write while full is dropped, even if a pop occurs the same cycle; no overflow flag.
  - Pop and accepted write in the same cycle leave level unchanged.
  - Pointers wrap modulo DEPTH.
- Divider:
  - Counts 0..rate_div; tick when count==rate_div, then count returns to 0.
  - rate_div=0 gives a tick every cycle.
  - Count is cleared on entry to RUN and FLUSH; the first tick occurs rate_div+1 cycles after entry.
  - rate_div is sampled live.
- FSM, states IDLE, RUN, FLUSH:
  - IDLE: no strobes.
    - start with !stop → RUN, and underrun clears.
    - start && stop in the same cycle → stay IDLE.
  - RUN, on tick:
    - If level>0: pop head, x_out<=head, x_valid<=1.
    - If level==0: x_out<=0, x_valid<=1, underrun<=1.
    - stop → FLUSH; stop has priority, so no pop occurs on that cycle even if it is a tick.
    - start ignored.
  - FLUSH, on tick: x_out<=0, x_valid<=1, increment flush count.
    - After the FLUSH_LEN-th zero → IDLE.
    - start/stop ignored.
    - FIFO contents retained.
- Timing and outputs:
  - Latency is one cycle: x_valid/x_out are registered in the cycle following the tick condition.
  - x_valid is high exactly one cycle per strobe; x_out holds its last value between strobes.
  - All outputs are registered except full and level, which decode from registered pointers/count.
- Async reset mid-RUN/FLUSH:
  - Immediately returns to reset values.
  - FIFO contents are discarded (level=0).

Optional Feature:
- Macro: FEEDER_LOOP_EN.
- Defined:
  - In RUN, each popped sample is simultaneously rewritten at the tail (circular playback), so level stays constant and the buffer repeats indefinitely.
  - wr_en is ignored while busy=1.
  - underrun is possible only if streaming starts with an empty FIFO.
- Undefined: popped samples are consumed; the FIFO drains normally.

Test Plan:
- Reset: rst=0 with a prior write → x_out=0, x_valid=0, level=0, full=0, busy=0, underrun=0.
- Write 1,2,3,4; rate_div=0; start → x_valid high 4 consecutive cycles carrying 1,2,3,4, then a strobe with x_out=0 and underrun=1; level=0.
- rate_div=2; write 5,6; start → strobes exactly 3 cycles apart with 5 then 6; no strobe in between.
- Write 1..6; rate_div=0; start; stop after the 2nd strobe → 4 zero strobes in FLUSH, then busy=0, level=4, underrun=0.
- Write 17 samples in IDLE → full=1 after the 16th, 17th dropped, level=16; streaming returns the first 16 in order.
- Assert rst low mid-RUN with level=3 → all outputs to reset values asynchronously, level=0; after release, start with an empty FIFO gives zero strobes and underrun=1.
- With FEEDER_LOOP_EN: write 7,8; start → repeating strobe pattern 7,8,7,8…, level stays 2.
